acq_sequencer: RTL

- Sits directly downstream of the controller FSM; consumes its cpu_trig pulse and the repetitions / samples / generator_hops configuration words.
- On a CPU trigger it runs one acquisition: for each generator hop it runs `repetitions` shots.
- Each shot waits for a hardware trigger edge, then gates `samples` ADC cycles.
- Emits hop strobes to the generator and a done strobe back to the CPU side.

---
 rtl/acq_sequencer.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/acq_sequencer.sv
// acq_sequencer: runs one acquisition per accepted cpu_trig pulse.
// For each generator hop it runs `repetitions` shots; each shot waits for a
// rising edge on ext_trig and then gates `samples` ADC cycles.
//
// Handshake: cpu_trig is a fire-and-forget one-cycle start request. It is
// accepted only in IDLE (busy=0); while busy=1 it is ignored. Completion is
// reported by a one-cycle done strobe, during which busy is still 1.
module acq_sequencer #(
  parameter int CNT_W      = 24,
  parameter int HOP_SETTLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_trig,
  input  logic [CNT_W-1:0] repetitions,
  input  logic [CNT_W-1:0] samples,
  input  logic [CNT_W-1:0] generator_hops,
  input  logic             ext_trig,
  output logic             busy,
  output logic             capture_en,
  output logic [CNT_W-1:0] sample_idx,
  output logic [CNT_W-1:0] rep_idx,
  output logic [CNT_W-1:0] hop_idx,
  output logic             hop_pulse,
  output logic             done,
  output logic             trig_overrun
);

  localparam int SET_W = (HOP_SETTLE > 1) ? $clog2(HOP_SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOP     = 3'd3,
    S_SETTLE  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state;
  state_t state_nxt;

  // Run configuration captured at start; later input changes do not matter.
  logic [CNT_W-1:0] rep_cfg;
  logic [CNT_W-1:0] smp_cfg;
  logic [CNT_W-1:0] hop_cfg;

  logic             ext_d;
  logic             trig_edge;
  logic [SET_W-1:0] settle_cnt;

  logic start_ok;
  logic last_sample;
  logic last_rep;
  logic last_hop;
  logic settle_done;
  logic overrun_state;

  assign trig_edge = ext_trig & ~ext_d;

  // Zero R or S means an empty run that completes immediately.
  assign start_ok = (repetitions != '0) && (samples != '0);

  // The shadow values are nonzero whenever these compares are used, so the
  // subtractions cannot wrap.
  assign last_sample = (sample_idx == (smp_cfg - CNT_W'(1)));
  assign last_rep    = (rep_idx == (rep_cfg - CNT_W'(1)));
  assign last_hop    = (hop_idx == (hop_cfg - CNT_W'(1)));
  assign settle_done = (settle_cnt == SET_W'(HOP_SETTLE - 1));

  assign overrun_state = (state == S_CAPTURE) || (state == S_HOP) ||
                         (state == S_SETTLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection and state-decoded strobes.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    capture_en = 1'b0;
    hop_pulse  = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (cpu_trig) begin
          state_nxt = start_ok ? S_ARM : S_DONE;
        end
      end
      S_ARM: begin
        if (trig_edge) begin
          state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        capture_en = 1'b1;
        if (last_sample) begin
          if (!last_rep) begin
            state_nxt = S_ARM;
          end else if (!last_hop) begin
            state_nxt = S_HOP;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_HOP: begin
        hop_pulse = 1'b1;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_done) begin
          state_nxt = S_ARM;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ext_trig history flop used for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_d <= 1'b0;
    end else begin
      ext_d <= ext_trig;
    end
  end

  // Shadow configuration, index counters, settle timer and overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_cfg      <= '0;
      smp_cfg      <= '0;
      hop_cfg      <= '0;
      sample_idx   <= '0;
      rep_idx      <= '0;
      hop_idx      <= '0;
      settle_cnt   <= '0;
      trig_overrun <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cpu_trig) begin
            rep_cfg      <= repetitions;
            smp_cfg      <= samples;
            hop_cfg      <= (generator_hops == '0) ? CNT_W'(1) : generator_hops;
            sample_idx   <= '0;
            rep_idx      <= '0;
            hop_idx      <= '0;
            trig_overrun <= 1'b0;
          end
        end
        S_ARM: begin
          if (trig_edge) begin
            sample_idx <= '0;
          end
        end
        S_CAPTURE: begin
          // sample_idx parks at S-1 after the last sample so it reads back
          // as the final index once the run is over.
          if (last_sample) begin
            if (!last_rep) begin
              rep_idx <= rep_idx + CNT_W'(1);
            end
          end else begin
            sample_idx <= sample_idx + CNT_W'(1);
          end
        end
        S_HOP: begin
          hop_idx    <= hop_idx + CNT_W'(1);
          rep_idx    <= '0;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
      // Edges outside ARM during a run are flagged, never acted upon.
      if (trig_edge && overrun_state) begin
        trig_overrun <= 1'b1;
      end
    end
  end

endmodule
